// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths, complex sample type and the
// bit-reversal helper used by the reorder buffer and the fft datapath.
package fft_pkg;

    localparam int unsigned W_DEF     = 11;
    localparam int unsigned LOG2N_DEF = 6;
    // Widest index the bit-reversal helper handles (LOG2N up to 12)
    localparam int unsigned IDX_W     = 12;

    typedef struct packed {
        logic [W_DEF-1:0] re;
        logic [W_DEF-1:0] im;
    } cplx_t;

    // Reverse the low log2n bits of idx; bits above log2n return as zero.
    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] idx,
                                                input int unsigned    log2n);
        logic [IDX_W-1:0] rev;
        rev = {<<{idx}};
        return rev >> (IDX_W - log2n);
    endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// Simple dual-port synchronous RAM holding both ping-pong banks; the bank
// select is the address MSB.
// Ports: clk, rst_n (clears the read register only), we_i/waddr_i/wdata_i
// write port, re_i/raddr_i read port, rdata_o registered read data that
// holds its value when re_i is low.
module fft_bank_ram #(
    parameter int unsigned DW = 22,
    parameter int unsigned AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage array: no reset so it maps onto a RAM macro
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong frame buffer: collects N = 2**LOG2N complex samples per bank and
// releases completed banks to a pull-driven reader in natural or bit-reversed
// order.
// Ports: CLK/RST (async active-low), valid_a/ar/ai input stream, full
// backpressure, rd_en pull, valid_o/xr/xi/frame_o output stream (1-cycle
// latency), overflow sticky drop flag, state = count of unread complete banks.
module fft_reorder_buf
    import fft_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned LOG2N  = LOG2N_DEF,
    parameter int unsigned BITREV = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         valid_a,
    input  logic [W-1:0] ar,
    input  logic [W-1:0] ai,
    output logic         full,
    input  logic         rd_en,
    output logic         valid_o,
    output logic [W-1:0] xr,
    output logic [W-1:0] xi,
    output logic         frame_o,
    output logic         overflow,
    output logic [1:0]   state
);

    localparam int unsigned AW = LOG2N + 1;
    localparam int unsigned DW = 2 * W;
    localparam int unsigned N  = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic [LOG2N-1:0] wcnt_q, rcnt_q;
    logic             wbank_q, rbank_q;
    logic [1:0]       state_q, state_d;
    logic             full_q, ovf_q, valid_q, frame_q;

    logic             we, re, wr_done, rd_done;
    logic [LOG2N-1:0] rd_idx;

    // Accept/release decisions and next bank count
    always_comb begin
        we      = valid_a & ~full_q;
        re      = rd_en & (state_q != 2'd0);
        wr_done = we & (wcnt_q == LAST);
        rd_done = re & (rcnt_q == LAST);
        state_d = state_q;
        case ({wr_done, rd_done})
            2'b10:   state_d = state_q + 2'd1;
            2'b01:   state_d = state_q - 2'd1;
            default: state_d = state_q;
        endcase
        if (BITREV != 0) begin
            rd_idx = LOG2N'(bitrev(IDX_W'(rcnt_q), LOG2N));
        end else begin
            rd_idx = rcnt_q;
        end
    end

    // Counters, bank pointers and flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            state_q <= 2'd0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            if (we) begin
                wcnt_q <= wcnt_q + LOG2N'(1);
                if (wr_done) begin
                    wbank_q <= ~wbank_q;
                end
            end
            if (re) begin
                rcnt_q <= rcnt_q + LOG2N'(1);
                if (rd_done) begin
                    rbank_q <= ~rbank_q;
                end
            end
            state_q <= state_d;
            full_q  <= (state_d == 2'd2);
            ovf_q   <= ovf_q | (valid_a & full_q);
            valid_q <= re;
            frame_q <= re & (rcnt_q == '0);
        end
    end

    fft_bank_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (CLK),
        .rst_n   (RST),
        .we_i    (we),
        .waddr_i ({wbank_q, wcnt_q}),
        .wdata_i ({ar, ai}),
        .re_i    (re),
        .raddr_i ({rbank_q, rd_idx}),
        .rdata_o ({xr, xi})
    );

    assign full     = full_q;
    assign valid_o  = valid_q;
    assign frame_o  = frame_q;
    assign overflow = ovf_q;
    assign state    = state_q;

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Directed bench for fft_reorder_buf: an N=8 natural-order instance for
// control scenarios and an N=64 bit-reversed instance for ordering.
module tb_fft_reorder_buf;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // N=8, natural order
    logic        v3, rd3, full3, vo3, fr3, ov3;
    logic [10:0] ar3, ai3, x3r, x3i;
    logic [1:0]  st3;
    // N=64, bit-reversed order
    logic        v6, rd6, full6, vo6, fr6, ov6;
    logic [10:0] ar6, ai6, x6r, x6i;
    logic [1:0]  st6;

    fft_reorder_buf #(.W(11), .LOG2N(3), .BITREV(0)) dut3 (
        .CLK(clk), .RST(rst_n), .valid_a(v3), .ar(ar3), .ai(ai3), .full(full3),
        .rd_en(rd3), .valid_o(vo3), .xr(x3r), .xi(x3i), .frame_o(fr3),
        .overflow(ov3), .state(st3)
    );

    fft_reorder_buf #(.W(11), .LOG2N(6), .BITREV(1)) dut6 (
        .CLK(clk), .RST(rst_n), .valid_a(v6), .ar(ar6), .ai(ai6), .full(full6),
        .rd_en(rd6), .valid_o(vo6), .xr(x6r), .xi(x6i), .frame_o(fr6),
        .overflow(ov6), .state(st6)
    );

    function automatic int brev6(input int k);
        int r;
        r = 0;
        for (int b = 0; b < 6; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (5 - b));
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        v3 = 0; rd3 = 1; ar3 = '0; ai3 = '0;
        v6 = 0; rd6 = 1; ar6 = '0; ai6 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (full3 !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full3); end
        checks++; if (vo3 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", vo3); end
        checks++; if (st3 !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", st3); end
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ov3); end
        checks++; if ({x3r, x3i} !== 22'd0) begin errors++; $display("FAIL rst_data got %h exp 0", {x3r, x3i}); end
        checks++; if (vo6 !== 1'b0 || st6 !== 2'd0) begin errors++; $display("FAIL rst_dut6 got v=%b s=%0d exp 0/0", vo6, st6); end
        rd3 = 0; rd6 = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_natural();
        for (int k = 0; k < 8; k++) begin
            v3 = 1; ar3 = 11'(k); ai3 = 11'(-k);
            @(posedge clk); #1;
        end
        v3 = 0;
        checks++; if (st3 !== 2'd1) begin errors++; $display("FAIL nat_state_w got %0d exp 1", st3); end
        for (int k = 0; k < 8; k++) begin
            rd3 = 1;
            @(posedge clk); #1;
            checks++; if (vo3 !== 1'b1) begin errors++; $display("FAIL nat_valid k=%0d got %b exp 1", k, vo3); end
            checks++; if (x3r !== 11'(k)) begin errors++; $display("FAIL nat_xr k=%0d got %0d exp %0d", k, x3r, k); end
            checks++; if (x3i !== 11'(-k)) begin errors++; $display("FAIL nat_xi k=%0d got %h exp %h", k, x3i, 11'(-k)); end
            checks++; if (fr3 !== (k == 0)) begin errors++; $display("FAIL nat_frame k=%0d got %b", k, fr3); end
        end
        rd3 = 0;
        @(posedge clk); #1;
        checks++; if (vo3 !== 1'b0) begin errors++; $display("FAIL nat_idle_valid got %b exp 0", vo3); end
        checks++; if (st3 !== 2'd0) begin errors++; $display("FAIL nat_state_r got %0d exp 0", st3); end
        checks++; if (x3r !== 11'd7) begin errors++; $display("FAIL nat_hold got %0d exp 7", x3r); end
    endtask

    task automatic test_empty_read();
        rd3 = 1;
        @(posedge clk); #1;
        rd3 = 0;
        checks++; if (vo3 !== 1'b0) begin errors++; $display("FAIL empty_valid got %b exp 0", vo3); end
        checks++; if (x3r !== 11'd7 || x3i !== 11'(-7)) begin errors++; $display("FAIL empty_hold got %0d/%h exp 7/%h", x3r, x3i, 11'(-7)); end
        checks++; if (st3 !== 2'd0) begin errors++; $display("FAIL empty_state got %0d exp 0", st3); end
    endtask

    task automatic test_bitrev();
        int e;
        for (int k = 0; k < 64; k++) begin
            v6 = 1; ar6 = 11'(k); ai6 = 11'(-k);
            @(posedge clk); #1;
        end
        v6 = 0;
        checks++; if (st6 !== 2'd1) begin errors++; $display("FAIL br_state_w got %0d exp 1", st6); end
        for (int k = 0; k < 64; k++) begin
            rd6 = 1;
            @(posedge clk); #1;
            e = brev6(k);
            checks++; if (vo6 !== 1'b1) begin errors++; $display("FAIL br_valid k=%0d got %b exp 1", k, vo6); end
            checks++; if (x6r !== 11'(e)) begin errors++; $display("FAIL br_xr k=%0d got %0d exp %0d", k, x6r, e); end
            checks++; if (x6i !== 11'(-e)) begin errors++; $display("FAIL br_xi k=%0d got %h exp %h", k, x6i, 11'(-e)); end
            checks++; if (fr6 !== (k == 0)) begin errors++; $display("FAIL br_frame k=%0d got %b", k, fr6); end
        end
        rd6 = 0;
        @(posedge clk); #1;
        checks++; if (st6 !== 2'd0) begin errors++; $display("FAIL br_state_r got %0d exp 0", st6); end
        checks++; if (vo6 !== 1'b0) begin errors++; $display("FAIL br_idle got %b exp 0", vo6); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 16; k++) begin
            v3 = 1; ar3 = 11'(100 + k); ai3 = 11'(k);
            @(posedge clk); #1;
        end
        v3 = 0;
        checks++; if (full3 !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full3); end
        checks++; if (st3 !== 2'd2) begin errors++; $display("FAIL ovf_state got %0d exp 2", st3); end
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ov3); end
        v3 = 1; ar3 = 11'd55; ai3 = 11'd55;
        @(posedge clk); #1;
        v3 = 0;
        checks++; if (ov3 !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ov3); end
        checks++; if (st3 !== 2'd2) begin errors++; $display("FAIL ovf_state2 got %0d exp 2", st3); end
        // Release cycle carries a write that must still be dropped
        for (int k = 0; k < 8; k++) begin
            rd3 = 1;
            v3 = (k == 7); ar3 = 11'd77; ai3 = 11'd77;
            @(posedge clk); #1;
            checks++; if (x3r !== 11'(100 + k)) begin errors++; $display("FAIL ovf_b0 k=%0d got %0d exp %0d", k, x3r, 100 + k); end
        end
        v3 = 0; rd3 = 0;
        checks++; if (full3 !== 1'b0 || st3 !== 2'd1) begin errors++; $display("FAIL ovf_release got f=%b s=%0d exp 0/1", full3, st3); end
        for (int k = 0; k < 8; k++) begin
            rd3 = 1;
            @(posedge clk); #1;
            checks++; if (x3r !== 11'(108 + k) || x3i !== 11'(8 + k)) begin errors++; $display("FAIL ovf_b1 k=%0d got %0d/%0d exp %0d/%0d", k, x3r, x3i, 108 + k, 8 + k); end
        end
        rd3 = 0;
        for (int k = 0; k < 8; k++) begin
            v3 = 1; ar3 = 11'(200 + k); ai3 = 11'(-k);
            @(posedge clk); #1;
        end
        v3 = 0;
        for (int k = 0; k < 8; k++) begin
            rd3 = 1;
            @(posedge clk); #1;
            checks++; if (x3r !== 11'(200 + k) || fr3 !== (k == 0)) begin errors++; $display("FAIL ovf_recover k=%0d got %0d fr=%b exp %0d", k, x3r, fr3, 200 + k); end
        end
        rd3 = 0;
        checks++; if (ov3 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ov3); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] ei;
        for (int k = 0; k < 8; k++) begin
            v3 = 1; ar3 = 11'(k); ai3 = (k == 0) ? 11'd1 : 11'd0;
            @(posedge clk); #1;
        end
        for (int t = 0; t < 32; t++) begin
            v3 = 1; rd3 = 1;
            ar3 = 11'(t % 8); ai3 = ((t % 8) == 0) ? 11'd1 : 11'd0;
            @(posedge clk); #1;
            ei = ((t % 8) == 0) ? 11'd1 : 11'd0;
            checks++; if (vo3 !== 1'b1) begin errors++; $display("FAIL str_valid t=%0d got %b exp 1", t, vo3); end
            checks++; if (x3i !== ei || x3r !== 11'(t % 8)) begin errors++; $display("FAIL str_data t=%0d got %0d/%0d exp %0d/%0d", t, x3r, x3i, t % 8, ei); end
            checks++; if (fr3 !== ((t % 8) == 0)) begin errors++; $display("FAIL str_frame t=%0d got %b", t, fr3); end
            checks++; if (full3 !== 1'b0 || st3 !== 2'd1) begin errors++; $display("FAIL str_state t=%0d got f=%b s=%0d exp 0/1", t, full3, st3); end
        end
        v3 = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++; if (vo3 !== 1'b1 || x3r !== 11'(k)) begin errors++; $display("FAIL str_drain k=%0d got v=%b %0d exp 1 %0d", k, vo3, x3r, k); end
        end
        rd3 = 0;
        checks++; if (st3 !== 2'd0) begin errors++; $display("FAIL str_end got %0d exp 0", st3); end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 11; k++) begin
            v3 = 1; ar3 = 11'(k); ai3 = 11'd3;
            @(posedge clk); #1;
        end
        v3 = 0;
        checks++; if (st3 !== 2'd1) begin errors++; $display("FAIL mid_pre got %0d exp 1", st3); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (st3 !== 2'd0 || ov3 !== 1'b0 || full3 !== 1'b0) begin errors++; $display("FAIL mid_async got s=%0d o=%b f=%b exp 0", st3, ov3, full3); end
        checks++; if ({x3r, x3i} !== 22'd0 || vo3 !== 1'b0) begin errors++; $display("FAIL mid_data got %h v=%b exp 0", {x3r, x3i}, vo3); end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            v3 = 1; ar3 = 11'(300 + k); ai3 = 11'(k);
            @(posedge clk); #1;
        end
        v3 = 0;
        for (int k = 0; k < 8; k++) begin
            rd3 = 1;
            @(posedge clk); #1;
            checks++; if (x3r !== 11'(300 + k) || x3i !== 11'(k)) begin errors++; $display("FAIL mid_after k=%0d got %0d/%0d exp %0d/%0d", k, x3r, x3i, 300 + k, k); end
        end
        rd3 = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_natural();
        test_empty_read();
        test_bitrev();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
